// File: rtl/compress_ctrl_pkg.sv
// Shared types and sizing for the output-map compressor controller.
package compress_pkg;

  localparam int unsigned CMP_WIN = 16;  // bytes presented to the compressor per cycle
  localparam int unsigned CMP_BUF = 32;  // staging window depth in bytes

  typedef logic [7:0]               byte_t;
  typedef byte_t [CMP_WIN-1:0]      win_vec_t;
  typedef byte_t [CMP_BUF-1:0]      buf_vec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } compress_ctrl_state_t;

endpackage

// File: rtl/compress_ctrl_stage_buf.sv
// 32-byte shift-and-append staging buffer. Each cycle the head is retired by
// take_num bytes and app_num new bytes are appended behind what remains.
module compress_stage_buf
  import compress_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [4:0] take_num,
  input  win_vec_t   app_data,
  input  logic [4:0] app_num,
  output win_vec_t   win,
  output logic [5:0] occ
);

  buf_vec_t   buf_q;
  buf_vec_t   buf_d;
  logic [5:0] occ_d;
  logic [5:0] base;
  logic [5:0] src;
  logic [5:0] dst;

  assign win = buf_q[CMP_WIN-1:0];

  // Next window: shift out consumed bytes (zero fill), then append behind the survivors.
  always_comb begin
    buf_d = '0;
    src   = '0;
    dst   = '0;
    base  = occ - {1'b0, take_num};
    for (int unsigned i = 0; i < CMP_BUF; i++) begin
      src = 6'(i) + {1'b0, take_num};
      if (src < 6'(CMP_BUF)) buf_d[5'(i)] = buf_q[src[4:0]];
    end
    for (int unsigned j = 0; j < CMP_WIN; j++) begin
      dst = base + 6'(j);
      if ((5'(j) < app_num) && (dst < 6'(CMP_BUF))) buf_d[dst[4:0]] = app_data[4'(j)];
    end
    occ_d = base + {1'b0, app_num};
  end

  // Buffer and occupancy registers; clear empties the window at layer start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      occ   <= '0;
    end else if (clear) begin
      buf_q <= '0;
      occ   <= '0;
    end else begin
      buf_q <= buf_d;
      occ   <= occ_d;
    end
  end

endmodule

// File: rtl/compress_ctrl.sv
// Sequencing controller for the output-map compressor: stages input beats,
// presents up to 16 bytes per cycle, and forwards compressed words to SRAM.
module compress_ctrl
  import compress_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [15:0]       cfg_total_num,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0][7:0]  in_data,
  input  logic [4:0]        in_num,
  output logic              cmp_start,
  output logic [15:0][7:0]  cmp_data,
  output logic [4:0]        cmp_valid_num,
  input  logic [4:0]        cmp_taken_num,
  input  logic              cmp_mem_req,
  input  logic [63:0]       cmp_compressed_data,
  output logic              cmp_mem_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [63:0]       wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       words_written
);

  compress_ctrl_state_t state;
  logic [15:0] total_q;
  logic [15:0] received_q;
  logic [15:0] consumed_q;
  logic [5:0]  occ;
  win_vec_t    win;
  logic        in_run;
  logic        wr_phase;
  logic        stall;
  logic        accept;
  logic        wr_hs;
  logic        final_take;
  logic        buf_clear;
  logic [4:0]  take_num;
  logic [4:0]  app_num;
  logic [15:0] remaining;
  logic [15:0] room;
  logic [16:0] consumed_sum;

  compress_stage_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (buf_clear),
    .take_num (take_num),
    .app_data (in_data),
    .app_num  (app_num),
    .win      (win),
    .occ      (occ)
  );

  assign cmp_data = win;

  // Handshake decode and window presentation, all from registered state.
  always_comb begin
    in_run       = (state == ST_RUN);
    wr_phase     = (state == ST_RUN) || (state == ST_DRAIN);
    stall        = cmp_mem_req && !wr_ready;
    remaining    = total_q - consumed_q;
    room         = total_q - received_q;
    in_ready     = in_run && (occ <= 6'(CMP_WIN)) && (received_q < total_q);
    accept       = in_valid && in_ready;
    // Bytes past the layer end in the last beat are dropped.
    app_num      = '0;
    if (accept) app_num = (16'(in_num) > room) ? room[4:0] : in_num;
    take_num     = in_run ? cmp_taken_num : '0;
    consumed_sum = {1'b0, consumed_q} + 17'(take_num);
    final_take   = in_run && (consumed_sum == {1'b0, total_q});
    buf_clear    = (state == ST_IDLE) && cfg_start;
    // A full window holding exactly the last 16 bytes is shown as 15 so the
    // final take is always partial and the compressor emits its last word.
    if (!in_run || stall)           cmp_valid_num = '0;
    else if (occ >= 6'(CMP_WIN))    cmp_valid_num = ((occ == 6'(CMP_WIN)) && (remaining == 16'(CMP_WIN)))
                                                    ? 5'(CMP_WIN - 1) : 5'(CMP_WIN);
    else                            cmp_valid_num = occ[4:0];
    wr_en       = wr_phase && cmp_mem_req;
    cmp_mem_ack = wr_phase && wr_ready;
    wr_hs       = wr_en && wr_ready;
    wr_data     = wr_phase ? cmp_compressed_data : '0;
  end

  // Layer FSM with registered status outputs and write address/count tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      total_q       <= '0;
      received_q    <= '0;
      consumed_q    <= '0;
      wr_addr       <= '0;
      words_written <= '0;
      cmp_start     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      if (wr_hs) begin
        wr_addr       <= wr_addr + ADDR_W'(1);
        words_written <= words_written + 16'd1;
      end
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            total_q       <= cfg_total_num;
            wr_addr       <= cfg_base_addr;
            received_q    <= '0;
            consumed_q    <= '0;
            words_written <= '0;
            cmp_start     <= 1'b1;
            busy          <= 1'b1;
            state         <= ST_START;
          end
        end
        ST_START: begin
          cmp_start <= 1'b0;
          state     <= ST_RUN;
        end
        ST_RUN: begin
          received_q <= received_q + 16'(app_num);
          consumed_q <= consumed_sum[15:0];
          if (final_take) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (wr_hs) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  taken_le_valid: assert property (@(posedge clk) disable iff (!rst_n)
                                   cmp_taken_num <= cmp_valid_num);

endmodule

// File: doc/compress_ctrl.md
# compress_ctrl

Sequencing controller for the output-map compressor. It accepts packed output-map beats from the PE array, stages them in a 32-byte window buffer and presents up to 16 bytes per cycle to the compressor. It retires the number of bytes the compressor reports as taken. It also forwards each 64-bit compressed word to the output SRAM write port at consecutive addresses, and guarantees the last partial word of a layer is flushed.

## Interface
- ADDR_W, 16, output SRAM word-address width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle pulse to begin a layer; ignored while busy
- cfg_base_addr  in  ADDR_W  first write address; sampled on accepted cfg_start
- cfg_total_num  in  16  layer size in bytes, 1..65535; sampled on accepted cfg_start
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  [15:0][7:0]  packed bytes, valid from index 0
- in_num  in  5  valid bytes in beat, 1..16
- cmp_start  out  1  compressor group reset pulse
- cmp_data  out  [15:0][7:0]  window buffer bytes 0..15
- cmp_valid_num  out  5  valid bytes presented, 0..16
- cmp_taken_num  in  5  bytes consumed by compressor this cycle
- cmp_mem_req  in  1  compressed word ready
- cmp_compressed_data  in  64  compressed word
- cmp_mem_ack  out  1  word accepted by memory
- wr_en  out  1  SRAM write request
- wr_addr  out  ADDR_W  SRAM word address
- wr_data  out  64  SRAM write data (= cmp_compressed_data)
- wr_ready  in  1  SRAM accepts write
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse after last word written
- words_written  out  16  words written in current/last layer

## Operation
- States: IDLE, START, RUN, DRAIN, DONE.
- IDLE: on cfg_start, latch base/total; clear occ, consumed and words_written; go to START.
- START: one cycle. cmp_start=1, cmp_valid_num=0, in_ready=0. Go to RUN.
- RUN:
  - in_ready = (occ <= 16) && (received < total).
  - Append is placed at buffer index occ - cmp_taken_num, after the consume shift.
  - occ_next = occ - taken + (accepted ? in_num : 0). Bytes beyond total in the last beat are dropped; received saturates at total.
  - cmp_valid_num = min(occ, 16).
  - Exception: if occ == 16 and total - consumed == 16, present 15. The final take then always has valid_num < 16, which forces a compressor mem_req.
  - cmp_valid_num is forced to 0 while cmp_mem_req && !wr_ready (stall).
  - When consumed + taken == total, go to DRAIN.
- wr_en = cmp_mem_req in RUN or DRAIN. cmp_mem_ack = wr_ready in RUN or DRAIN, else 0.
- On wr_en && wr_ready: wr_addr increments (modulo 2^ADDR_W, wraps silently) and words_written increments.
- DRAIN: in_ready=0, cmp_valid_num=0. On a write handshake, go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy=1 in START/RUN/DRAIN/DONE.
- cmp_taken_num > cmp_valid_num is a protocol error and is asserted in simulation only.

## Timing
- Reset values: state IDLE, all outputs 0, wr_addr 0, words_written 0.
- An async reset mid-layer discards buffer contents and aborts the layer; no done pulse is issued.
- in_ready, cmp_valid_num, wr_en and cmp_mem_ack are combinational from registered state, occ and input handshakes. There is no combinational path from in_valid to in_ready.
- Consume and append in the same cycle are both applied. The window presented next cycle reflects both.
- A write handshake and a compressor take may occur in the same cycle (compressor restarts on ack).
- Latency: first input byte reaches cmp_data 1 cycle after acceptance. done is asserted ≥1 cycle after the final take.
- cfg_start during busy is ignored. cfg_start in the DONE cycle is ignored.

## Structure
- Shared package compress_pkg:
  - state enum compress_ctrl_state_t
  - CMP_WIN=16, CMP_BUF=32
  - byte vector typedef
- Sub-module compress_stage_buf: 32-byte shift-and-append buffer with occ counter. Inputs are take count, append data and append count.

## Test plan
- total=16, one beat in_num=16, compressor takes 15 then 1: cmp_valid_num reads 15, then 1. One word is written at base, then done; words_written=1.
- total=40, beats of 16/16/8 with compressor taking 4 per cycle: in_ready drops when occ=20 and reasserts at occ≤16. All 40 bytes are presented in order with no loss or duplication.
- wr_ready held low 5 cycles while cmp_mem_req=1: cmp_valid_num=0 and wr_addr stable for 5 cycles. Address increments once on release.
- cfg_base_addr=0xFFFF with 3 words written: addresses 0xFFFF, 0x0000, 0x0001.
- total=10, beat in_num=16: only 10 bytes are retained, and DRAIN is entered after the 10th byte is taken.
- rst_n asserted mid-RUN with occ=12: all outputs are 0 immediately. A new cfg_start then runs a clean layer with words_written starting at 0.
